// File: rtl/accum_writeback_l17_pkg.sv
// Shared constants, stage codes and arithmetic helpers for the layer-17
// accumulate/writeback slice.
package pkg_l17;

    localparam int PSUM_W = 16;
    localparam int ACC_W  = 24;
    localparam int DATA_W = 8;
    localparam int QSHIFT = 7;
    localparam int ADDR_W = 10;

    typedef enum logic [2:0] {
        U_CONV60 = 3'd0,
        U_CONV61 = 3'd1,
        U_CONV62 = 3'd2,
        U_CONV63 = 3'd3,
        U_CONV64 = 3'd4,
        U_CONV65 = 3'd5
    } stage_e;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   RND_HALF = (ACC_W+1)'(1) << (QSHIFT-1);
    localparam logic signed [ACC_W:0]   D_MAX = (ACC_W+1)'((2**(DATA_W-1))-1);
    localparam logic signed [ACC_W:0]   D_MIN = ~D_MAX;

    // Clamp a one-bit-wider sum back into the accumulator range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
        if (x[ACC_W] != x[ACC_W-1])
            return x[ACC_W] ? ACC_MIN : ACC_MAX;
        return x[ACC_W-1:0];
    endfunction

    // Arithmetic shift by QSHIFT with round-half-up; result kept wide.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W:0] t;
        t = {x[ACC_W-1], x} + RND_HALF;
        return t >>> QSHIFT;
    endfunction

    // Saturate a wide signed value to the output activation range.
    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W:0] x);
        if (x > D_MAX)
            return D_MAX[DATA_W-1:0];
        if (x < D_MIN)
            return D_MIN[DATA_W-1:0];
        return x[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/accum_writeback_l17_if.sv
// Controller-to-writeback bus for layer 17: psum/control inputs and the
// BRAM2 write port. skip_data exists only when SKIP_ADD_EN is defined.
interface accum_writeback_l17_if;
    import pkg_l17::*;

    logic [2:0]        u;
    logic              load;
    logic              padding;
    logic              temp_zero;
    logic              psum_valid;
    logic [PSUM_W-1:0] psum_in;
    logic [ADDR_W-1:0] wr_addr_in;
`ifdef SKIP_ADD_EN
    logic [DATA_W-1:0] skip_data;
`endif
    logic              bram_we;
    logic [ADDR_W-1:0] bram_waddr;
    logic [DATA_W-1:0] bram_wdata;
    logic [ADDR_W-1:0] wr_count;

    modport master (
        output u, load, padding, temp_zero, psum_valid, psum_in, wr_addr_in,
`ifdef SKIP_ADD_EN
        output skip_data,
`endif
        input  bram_we, bram_waddr, bram_wdata, wr_count
    );

    modport slave (
        input  u, load, padding, temp_zero, psum_valid, psum_in, wr_addr_in,
`ifdef SKIP_ADD_EN
        input  skip_data,
`endif
        output bram_we, bram_waddr, bram_wdata, wr_count
    );

endinterface

// File: rtl/accum_writeback_l17_requant.sv
// requant_relu_l17: S2 register stage. Round-shifts the closed group sum,
// saturates to 8 bits, applies ReLU except on conv65, and (SKIP_ADD_EN)
// adds the skip activation on conv65.
module requant_relu_l17
    import pkg_l17::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [ACC_W-1:0]  in_sum,
    input  logic [2:0]               in_u,
    input  logic [ADDR_W-1:0]        in_addr,
`ifdef SKIP_ADD_EN
    input  logic [DATA_W-1:0]        in_skip,
`endif
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data
);

    logic signed [DATA_W-1:0] q;
    logic [DATA_W-1:0]        res;

    // Requantise the group sum and select linear or ReLU output.
    always_comb begin
        q   = sat_data(round_shift(in_sum));
        res = q;
        if (in_u == U_CONV65) begin
`ifdef SKIP_ADD_EN
            res = sat_data({{(ACC_W+1-DATA_W){q[DATA_W-1]}}, q} +
                           {{(ACC_W+1-DATA_W){in_skip[DATA_W-1]}}, in_skip});
`else
            res = q;
`endif
        end else if (q[DATA_W-1]) begin
            res = '0;
        end
    end

    // Register the requantised byte with its destination address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_addr <= in_addr;
                out_data <= res;
            end
        end
    end

endmodule

// File: rtl/accum_writeback_l17.sv
// accum_writeback_l17: accumulates conv60..conv65 partial sums, closes a
// group on load, and writes one requantised byte to BRAM2 two cycles later.
// Optional feature: SKIP_ADD_EN adds skip_data to conv65 outputs.
module accum_writeback_l17
    import pkg_l17::*;
(
    input  logic                  clk,
    input  logic                  rst,
    accum_writeback_l17_if.slave  bus
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_next;
    logic                    stage_ok;

    logic                    s1_valid;
    logic signed [ACC_W-1:0] s1_sum;
    logic [2:0]              s1_u;
    logic [ADDR_W-1:0]       s1_addr;
`ifdef SKIP_ADD_EN
    logic [DATA_W-1:0]       s1_skip;
`endif

    logic                    s2_valid;
    logic [ADDR_W-1:0]       s2_addr;
    logic [DATA_W-1:0]       s2_data;

    // Current term and the saturated running sum including it.
    always_comb begin
        term = '0;
        if (bus.psum_valid && !bus.padding)
            term = {{(ACC_W-PSUM_W){bus.psum_in[PSUM_W-1]}}, bus.psum_in};
        acc_next = sat_acc({acc[ACC_W-1], acc} + {term[ACC_W-1], term});
        stage_ok = (bus.u <= U_CONV65);
    end

    // Accumulator: cleared by load (group closed) or temp_zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (bus.load || bus.temp_zero)
            acc <= '0;
        else
            acc <= acc_next;
    end

    // S1: capture the closed group; illegal stages never become valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_u     <= '0;
            s1_addr  <= '0;
`ifdef SKIP_ADD_EN
            s1_skip  <= '0;
`endif
        end else begin
            s1_valid <= bus.load && stage_ok;
            if (bus.load) begin
                s1_sum  <= acc_next;
                s1_u    <= bus.u;
                s1_addr <= bus.wr_addr_in;
`ifdef SKIP_ADD_EN
                s1_skip <= bus.skip_data;
`endif
            end
        end
    end

    requant_relu_l17 u_requant (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_sum    (s1_sum),
        .in_u      (s1_u),
        .in_addr   (s1_addr),
`ifdef SKIP_ADD_EN
        .in_skip   (s1_skip),
`endif
        .out_valid (s2_valid),
        .out_addr  (s2_addr),
        .out_data  (s2_data)
    );

    // S3: BRAM2 write port; address/data hold their last written values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bram_we    <= 1'b0;
            bus.bram_waddr <= '0;
            bus.bram_wdata <= '0;
        end else begin
            bus.bram_we <= s2_valid;
            if (s2_valid) begin
                bus.bram_waddr <= s2_addr;
                bus.bram_wdata <= s2_data;
            end
        end
    end

    // Write counter tracks bram_we; temp_zero restarts it, in-flight writes still count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.wr_count <= '0;
        else if (bus.temp_zero)
            bus.wr_count <= '0;
        else if (s2_valid)
            bus.wr_count <= bus.wr_count + 1'b1;
    end

endmodule

// File: tb/tb_accum_writeback_l17.sv
// Scoreboard bench for accum_writeback_l17: stimulus pushes expected writes
// computed from plain integer arithmetic; a negedge monitor checks them.
module tb_accum_writeback_l17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accum_writeback_l17_if bus ();

    accum_writeback_l17 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [7:0]  data;
    } exp_t;

    exp_t   sb[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc   = 0;
    longint model_acc = 0;
    int     mon_cnt = 0;
    bit     tz_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic longint floor_div(input longint n, input longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    // Reference output byte from the group sum, stage and skip value.
    function automatic int expect_data(input longint s, input int uu, input int skip);
        longint q;
        q = clamp(floor_div(s + 64, 128), -128, 127);
        if (uu == 5) begin
`ifdef SKIP_ADD_EN
            q = clamp(q + skip, -128, 127);
`endif
        end else if (q < 0) begin
            q = 0;
        end
        return int'(q);
    endfunction

    // One clock of stimulus; the model is updated and expectations pushed.
    task automatic step(input bit v, input logic [15:0] p, input bit pad, input bit ld,
                        input logic [2:0] uu, input logic [9:0] a, input logic [7:0] sk,
                        input bit tz);
        longint t;
        longint s;
        exp_t   e;
        bus.psum_valid = v;
        bus.psum_in    = p;
        bus.padding    = pad;
        bus.load       = ld;
        bus.u          = uu;
        bus.wr_addr_in = a;
        bus.temp_zero  = tz;
`ifdef SKIP_ADD_EN
        bus.skip_data  = sk;
`endif
        @(posedge clk);
        #1;
        t = (v && !pad) ? longint'($signed(p)) : 0;
        s = clamp(model_acc + t, -(64'sd1 <<< 23), (64'sd1 <<< 23) - 1);
        if (ld) begin
            if (uu <= 3'd5) begin
                e.cyc  = cyc + 2;
                e.addr = a;
                e.data = 8'(expect_data(s, int'(uu), int'($signed(sk))));
                sb.push_back(e);
            end
            model_acc = 0;
        end else begin
            model_acc = s;
        end
        if (tz) model_acc = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0, '0, 0);
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_cnt = 0;
            tz_prev = 0;
        end else begin
            if (tz_prev) mon_cnt = 0;
            if (bus.bram_we) begin
                mon_cnt = (mon_cnt + 1) % 1024;
                if (sb.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("write_cycle", cyc, e.cyc);
                    chk("waddr", bus.bram_waddr, e.addr);
                    chk("wdata", $signed(bus.bram_wdata), $signed(e.data));
                    chk("wr_count", bus.wr_count, mon_cnt);
                end
            end
            if (sb.size() != 0 && cyc > sb[0].cyc) begin
                chk("missing_write", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            tz_prev = bus.temp_zero;
        end
    end

    initial begin
        int n;
        int uu;
        bus.psum_valid = 0; bus.psum_in = '0; bus.padding = 0; bus.load = 0;
        bus.u = '0; bus.wr_addr_in = '0; bus.temp_zero = 0;
`ifdef SKIP_ADD_EN
        bus.skip_data = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_we", bus.bram_we, 0);
        chk("rst_waddr", bus.bram_waddr, 0);
        chk("rst_wdata", bus.bram_wdata, 0);
        chk("rst_wr_count", bus.wr_count, 0);
        @(posedge clk); #1;

        // u=0: 100+200-50 -> 2 at address 0x12
        step(1, 16'd100, 0, 0, 3'd0, 10'h000, '0, 0);
        step(1, 16'd200, 0, 0, 3'd0, 10'h000, '0, 0);
        step(1, -16'sd50, 0, 1, 3'd0, 10'h012, '0, 0);
        idle(3);
        // padding on the second term
        step(1, 16'd1000, 0, 0, 3'd0, '0, '0, 0);
        step(1, 16'd1000, 1, 1, 3'd0, 10'h013, '0, 0);
        idle(3);
        // ReLU vs linear stage
        step(1, -16'sd5000, 0, 1, 3'd1, 10'h020, '0, 0);
        step(1, -16'sd5000, 0, 1, 3'd5, 10'h021, 8'd0, 0);
        idle(3);
        // saturation then back-to-back empty load
        for (int i = 0; i < 300; i++) step(1, 16'sd32767, 0, 0, 3'd2, '0, '0, 0);
        step(0, '0, 0, 1, 3'd2, 10'h030, '0, 0);
        step(0, '0, 0, 1, 3'd2, 10'h031, '0, 0);
        idle(3);
        // negative saturation on linear stage
        for (int i = 0; i < 300; i++) step(1, 16'h8000, 0, 0, 3'd5, '0, '0, 0);
        step(0, '0, 0, 1, 3'd5, 10'h032, '0, 0);
        idle(3);
        // linear stage q=100 with skip 60
        step(1, 16'd12800, 0, 1, 3'd5, 10'h040, 8'd60, 0);
        idle(3);
        // illegal stage is dropped and clears the accumulator
        step(1, 16'd5000, 0, 1, 3'd6, 10'h050, '0, 0);
        step(1, 16'd640, 0, 1, 3'd0, 10'h051, '0, 0);
        idle(3);
        // temp_zero together with load: write still happens, count restarts
        step(1, 16'd256, 0, 0, 3'd0, '0, '0, 0);
        step(1, 16'd256, 0, 1, 3'd0, 10'h060, '0, 1);
        idle(3);
        @(negedge clk);
        chk("wr_count_after_tz", bus.wr_count, 1);
        // temp_zero alone flushes the partial group
        step(1, 16'd3000, 0, 0, 3'd0, '0, '0, 0);
        step(0, '0, 0, 0, 3'd0, '0, '0, 1);
        step(1, 16'd128, 0, 1, 3'd0, 10'h061, '0, 0);
        idle(3);

        // reset in the middle of a group
        step(1, 16'd700, 0, 0, 3'd0, '0, '0, 0);
        step(1, 16'd700, 0, 0, 3'd0, '0, '0, 0);
        bus.psum_valid = 1; bus.psum_in = 16'd700;
        #2 rst = 1;
        bus.psum_valid = 0; bus.psum_in = '0;
        model_acc = 0;
        @(negedge clk);
        chk("mid_rst_we", bus.bram_we, 0);
        chk("mid_rst_waddr", bus.bram_waddr, 0);
        chk("mid_rst_wdata", bus.bram_wdata, 0);
        chk("mid_rst_wr_count", bus.wr_count, 0);
        @(posedge clk); #1 rst = 0;
        step(1, 16'd384, 0, 1, 3'd3, 10'h070, '0, 0);
        idle(3);

        // randomized groups
        for (int g = 0; g < 60; g++) begin
            n = $urandom_range(1, 8);
            uu = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            for (int k = 0; k < n - 1; k++)
                step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 4) == 0,
                     0, 3'(uu), '0, '0, 0);
            if ($urandom_range(0, 7) == 0) begin
                idle(3);
                step($urandom_range(0, 1), 16'($urandom), 0, 1, 3'(uu), 10'($urandom),
                     8'($urandom), 1);
            end else begin
                step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 4) == 0,
                     1, 3'(uu), 10'($urandom), 8'($urandom), 0);
            end
            idle($urandom_range(0, 2));
        end
        idle(5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
